uart_sram_loopback_ctrl: RTL
============================

// Module: uart_sram_loopback_ctrl
// PURPOSE
//  Sequencer between the UART and SRAM handshake wrappers (oen/wen/done style).
//  Receives LEN bytes from the UART and packs them little-endian into DATA_W-bit SRAM words from BASE.
//  Then reads the words back and transmits the bytes on the UART in the same order.
//  Runs once per start pulse; leaves the top level free to own the board pins.
// PARAMETERS
//  ADDR_W   20  SRAM word-address width
//  DATA_W   32  SRAM data width; multiple of 8; BPW = DATA_W/8 bytes per word
//  LEN_W    8   width of runtime byte count; max transfer 2**LEN_W-1 bytes
// PORTS
//  clk             in   1       single clock; all logic on posedge
//  rst_n           in   1       synchronous reset, active low
//  start           in   1       1-cycle pulse; accepted only in IDLE
//  base_addr       in   ADDR_W  first SRAM word address; sampled on start
//  len             in   LEN_W   byte count; sampled on start
//  uart_dataready  in   1       UART rx byte available
//  uart_oen        out  1       UART read strobe, low active
//  uart_wen        out  1       UART write strobe, low active
//  uart_din        out  8       byte to transmit
//  uart_dout       in   8       received byte
//  uart_done       in   1       UART op complete (level)
//  sram_oen        out  1       SRAM read strobe, low active
//  sram_wen        out  1       SRAM write strobe, low active
//  sram_addr       out  ADDR_W  SRAM word address
//  sram_din        out  DATA_W  write data
//  sram_dout       in   DATA_W  read data
//  sram_done       in   1       SRAM op complete (level)
//  busy            out  1       high from the cycle after start until DONE
//  done            out  1       1-cycle pulse on completion
//  state_o         out  4       current state code (for 7-seg debug)
// BEHAVIOUR
//  Reset: all strobes 1, uart_din/sram_din/sram_addr 0, busy 0, done 0, state IDLE.
//  States: IDLE, RX_WAIT, RX, WR_BEGIN, WR, RD_BEGIN, RD, TX_BEGIN, TX, [CK_BEGIN, CK], DONE.
//  IDLE: on start, latch base/len; clear cnt, byte index and the pack register.
//    len==0 -> DONE.
//  RX_WAIT: if uart_dataready, drive uart_oen=0 and go to RX.
//  RX: on uart_done, uart_oen=1 and place the byte in lane idx of the pack register.
//    If lane BPW-1 is filled or this is the last byte -> WR_BEGIN; else back to RX_WAIT.
//    Unfilled lanes of a final partial word are written as 0.
//  WR_BEGIN: sram_wen=0, then go to WR.
//  WR: on sram_done, sram_wen=1 and addr+1.
//    All len bytes received -> RD_BEGIN with addr=base; else -> RX_WAIT.
//  Every strobe is registered and held until its done is sampled high. It is released the same cycle.
//    A new strobe is issued no earlier than the cycle after release.
//  RD_BEGIN: sram_oen=0, then go to RD.
//  RD: on sram_done, sram_oen=1 and latch the word -> TX_BEGIN.
//  TX_BEGIN: uart_din=lane idx, uart_wen=0, then go to TX.
//  TX: on uart_done, uart_wen=1. Last byte -> CK_BEGIN, or DONE without the macro.
//    Lane BPW-1 -> addr+1, RD_BEGIN. Otherwise idx+1 -> TX_BEGIN.
//  DONE: done=1 for one cycle, busy=0, then IDLE.
//  Counters: byte cnt LEN_W bits; addr wraps modulo 2**ADDR_W, no error.
//  start while busy is ignored. rst_n low mid-transfer aborts immediately to reset values.
//  done and sram_done are never both high on a strobe edge, because a strobe waits for its own done only.
// CONFIGURATION
//  LOOPBACK_CHECKSUM_EN defined: XOR of all received bytes is accumulated during RX.
//    After the last echoed byte, CK_BEGIN/CK transmit it as one extra UART byte before DONE.
//    len==0 sends no checksum.
//  Not defined: no accumulator, CK states absent, DONE directly after the last echo.
// STRUCTURE
//  Shared package/include: state codes (4-bit localparams), strobe active level.
//  Sub-module byte_lane_mux: selects or inserts byte idx of a DATA_W word; used for pack and unpack.
//  FSM, counters and address live in this module.
// TESTING
//  1. DATA_W=32, base=0x00010, len=10, bytes 0x30..0x39 -> SRAM words:
//     [0x10]=0x33323130, [0x11]=0x37363534, [0x12]=0x00003938.
//     UART tx order is 0x30..0x39; done pulses once.
//  2. len=0 start -> done 2 cycles after start; no strobe ever low.
//  3. base=0xFFFFF, len=5 -> writes at 0xFFFFF then 0x00000 (wrap); echo intact.
//  4. sram_done delayed 7 cycles and uart_done random -> each strobe held low until its done.
//     No overlap of uart and sram strobes.
//  5. rst_n low during WR of word 2 -> next cycle all strobes 1, busy 0.
//     A fresh start with len=3 completes normally.
//  6. With LOOPBACK_CHECKSUM_EN, bytes 0x01,0x02,0x04 -> tx 0x01,0x02,0x04,0x07.

Source files
------------

// File: rtl/uart_sram_loopback_ctrl_pkg.sv
// Shared definitions for the UART<->SRAM loopback sequencer: 4-bit state
// codes (also shown on the debug display) and the strobe active level.
// The CK_* codes exist only when LOOPBACK_CHECKSUM_EN is defined.
package uart_sram_loopback_ctrl_pkg;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RX_WAIT  = 4'd1;
  localparam logic [3:0] S_RX       = 4'd2;
  localparam logic [3:0] S_WR_BEGIN = 4'd3;
  localparam logic [3:0] S_WR       = 4'd4;
  localparam logic [3:0] S_RD_BEGIN = 4'd5;
  localparam logic [3:0] S_RD       = 4'd6;
  localparam logic [3:0] S_TX_BEGIN = 4'd7;
  localparam logic [3:0] S_TX       = 4'd8;
`ifdef LOOPBACK_CHECKSUM_EN
  localparam logic [3:0] S_CK_BEGIN = 4'd9;
  localparam logic [3:0] S_CK       = 4'd10;
`endif
  localparam logic [3:0] S_DONE     = 4'd11;

  // Wrapper strobes are active low
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE     = S_IDLE,
    ST_RX_WAIT  = S_RX_WAIT,
    ST_RX       = S_RX,
    ST_WR_BEGIN = S_WR_BEGIN,
    ST_WR       = S_WR,
    ST_RD_BEGIN = S_RD_BEGIN,
    ST_RD       = S_RD,
    ST_TX_BEGIN = S_TX_BEGIN,
    ST_TX       = S_TX,
`ifdef LOOPBACK_CHECKSUM_EN
    ST_CK_BEGIN = S_CK_BEGIN,
    ST_CK       = S_CK,
`endif
    ST_DONE     = S_DONE
  } state_e;

  // Byte-lane index width; at least one bit even for byte-wide SRAMs
  function automatic int idx_width(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/uart_sram_loopback_ctrl_if.sv
// Handshake bundle between the loopback sequencer (master) and the
// UART/SRAM wrappers (slave). Strobes are active low, dones are levels.
interface uart_sram_loopback_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              uart_dataready;
  logic              uart_oen;
  logic              uart_wen;
  logic [7:0]        uart_din;
  logic [7:0]        uart_dout;
  logic              uart_done;
  logic              sram_oen;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;
  logic              sram_done;

  modport master (
    input  uart_dataready, uart_dout, uart_done, sram_dout, sram_done,
    output uart_oen, uart_wen, uart_din, sram_oen, sram_wen, sram_addr, sram_din
  );

  modport slave (
    output uart_dataready, uart_dout, uart_done, sram_dout, sram_done,
    input  uart_oen, uart_wen, uart_din, sram_oen, sram_wen, sram_addr, sram_din
  );
endinterface

// File: rtl/uart_sram_loopback_ctrl_byte_lane_mux.sv
// Byte-lane mux: reads byte idx of a word (unpack for TX) and produces the
// same word with byte idx replaced (pack during RX). Lane 0 is bits [7:0].
module uart_sram_loopback_ctrl_byte_lane_mux #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [7:0]        byte_i,
  output logic [7:0]        byte_o,
  output logic [DATA_W-1:0] word_o
);
  localparam int BPW = DATA_W / 8;

  logic [BPW-1:0][7:0] lanes;

  assign lanes  = word_i;
  assign byte_o = lanes[idx_i];

  for (genvar l = 0; l < BPW; l++) begin : g_lane
    assign word_o[l*8 +: 8] = (idx_i == IDX_W'(l)) ? byte_i : lanes[l];
  end
endmodule

// File: rtl/uart_sram_loopback_ctrl.sv
// UART -> SRAM -> UART loopback sequencer. Receives len bytes, packs them
// little-endian into SRAM words from base_addr, then reads them back and
// echoes them in order. Optional LOOPBACK_CHECKSUM_EN appends the XOR of all
// received bytes as one extra transmitted byte.
module uart_sram_loopback_ctrl
  import uart_sram_loopback_ctrl_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LEN_W-1:0]          len,
  uart_sram_loopback_ctrl_if.master bus,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                state_o
);
  localparam int BPW   = DATA_W / 8;
  localparam int IDX_W = idx_width(BPW);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] pack_q, pack_d;   // RX pack register, reused to hold the read word
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              uoen_q, uoen_d;
  logic              uwen_q, uwen_d;
  logic [7:0]        udin_q, udin_d;
  logic              soen_q, soen_d;
  logic              swen_q, swen_d;
  logic [DATA_W-1:0] sdin_q, sdin_d;
`ifdef LOOPBACK_CHECKSUM_EN
  logic [7:0]        ck_q, ck_d;
`endif

  logic [7:0]        lane_byte;
  logic [DATA_W-1:0] lane_word;
  logic [LEN_W-1:0]  cnt_inc;
  logic              last_byte;

  uart_sram_loopback_ctrl_byte_lane_mux #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_lane (
    .word_i (pack_q),
    .idx_i  (idx_q),
    .byte_i (bus.uart_dout),
    .byte_o (lane_byte),
    .word_o (lane_word)
  );

  assign cnt_inc   = cnt_q + LEN_W'(1);
  assign last_byte = (cnt_inc == len_q);

  // Next-state and registered-output decode; every strobe is held until its
  // own done is seen and released on that same edge
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pack_d  = pack_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    uoen_d  = uoen_q;
    uwen_d  = uwen_q;
    udin_d  = udin_q;
    soen_d  = soen_q;
    swen_d  = swen_q;
    sdin_d  = sdin_q;
`ifdef LOOPBACK_CHECKSUM_EN
    ck_d    = ck_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          addr_d  = base_addr;
          len_d   = len;
          cnt_d   = '0;
          idx_d   = '0;
          pack_d  = '0;
          busy_d  = 1'b1;
`ifdef LOOPBACK_CHECKSUM_EN
          ck_d    = '0;
`endif
          state_d = (len == '0) ? ST_DONE : ST_RX_WAIT;
        end
      end
      ST_RX_WAIT: begin
        if (bus.uart_dataready) begin
          uoen_d  = STROBE_ON;
          state_d = ST_RX;
        end
      end
      ST_RX: begin
        if (bus.uart_done) begin
          uoen_d = STROBE_OFF;
          pack_d = lane_word;
          cnt_d  = cnt_inc;
`ifdef LOOPBACK_CHECKSUM_EN
          ck_d   = ck_q ^ bus.uart_dout;
`endif
          if (idx_q == IDX_LAST || last_byte) begin
            idx_d   = '0;
            state_d = ST_WR_BEGIN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_RX_WAIT;
          end
        end
      end
      ST_WR_BEGIN: begin
        swen_d  = STROBE_ON;
        sdin_d  = pack_q;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (bus.sram_done) begin
          swen_d = STROBE_OFF;
          pack_d = '0;                  // unfilled lanes of a partial word stay 0
          if (cnt_q == len_q) begin
            addr_d  = base_q;
            cnt_d   = '0;
            state_d = ST_RD_BEGIN;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_RX_WAIT;
          end
        end
      end
      ST_RD_BEGIN: begin
        soen_d  = STROBE_ON;
        state_d = ST_RD;
      end
      ST_RD: begin
        if (bus.sram_done) begin
          soen_d  = STROBE_OFF;
          pack_d  = bus.sram_dout;
          state_d = ST_TX_BEGIN;
        end
      end
      ST_TX_BEGIN: begin
        udin_d  = lane_byte;
        uwen_d  = STROBE_ON;
        state_d = ST_TX;
      end
      ST_TX: begin
        if (bus.uart_done) begin
          uwen_d = STROBE_OFF;
          cnt_d  = cnt_inc;
          if (last_byte) begin
`ifdef LOOPBACK_CHECKSUM_EN
            state_d = ST_CK_BEGIN;
`else
            state_d = ST_DONE;
`endif
          end else if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_RD_BEGIN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_TX_BEGIN;
          end
        end
      end
`ifdef LOOPBACK_CHECKSUM_EN
      ST_CK_BEGIN: begin
        udin_d  = ck_q;
        uwen_d  = STROBE_ON;
        state_d = ST_CK;
      end
      ST_CK: begin
        if (bus.uart_done) begin
          uwen_d  = STROBE_OFF;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, data and strobe registers; reset aborts any transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      pack_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      uoen_q  <= STROBE_OFF;
      uwen_q  <= STROBE_OFF;
      udin_q  <= '0;
      soen_q  <= STROBE_OFF;
      swen_q  <= STROBE_OFF;
      sdin_q  <= '0;
`ifdef LOOPBACK_CHECKSUM_EN
      ck_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pack_q  <= pack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      uoen_q  <= uoen_d;
      uwen_q  <= uwen_d;
      udin_q  <= udin_d;
      soen_q  <= soen_d;
      swen_q  <= swen_d;
      sdin_q  <= sdin_d;
`ifdef LOOPBACK_CHECKSUM_EN
      ck_q    <= ck_d;
`endif
    end
  end

  assign bus.uart_oen  = uoen_q;
  assign bus.uart_wen  = uwen_q;
  assign bus.uart_din  = udin_q;
  assign bus.sram_oen  = soen_q;
  assign bus.sram_wen  = swen_q;
  assign bus.sram_addr = addr_q;
  assign bus.sram_din  = sdin_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign state_o       = state_q;
endmodule
